tag_demux_ddf: RTL and testbench

Downstream companion of the tagged multi-flux accumulator. It pops tagged result tokens `{tag, value}` from that stage's output FIFO and strips the tag. Each value is buffered in a per-flux FIFO of depth DEPTH, and each flux drains to its own push-style consumer independently. A stalled consumer on one flux never blocks tokens of other fluxes unless that flux's buffer is full.

---
 rtl/tag_demux_pkg.sv | 14 +
 rtl/tag_fifo.sv | 50 +++++
 rtl/tag_demux_ddf.sv | 79 +++++++
 tb/tb_tag_demux_ddf.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_demux_pkg.sv
// Shared constants, tag-width helper and parameter sanity checks for tag_demux_ddf.
package tag_demux_pkg;

   localparam int unsigned DROP_W = 8;

   function automatic int unsigned tag_w(input int unsigned flux);
      return $clog2(flux);
   endfunction

   function automatic bit params_ok(input int unsigned flux, input int unsigned depth);
      return (flux >= 2) && (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/tag_fifo.sv
// Per-flux circular buffer: memory, wrapping pointers and occupancy count.
module tag_fifo
   import tag_demux_pkg::*;
#(
   parameter int unsigned VW    = 7,
   parameter int unsigned DEPTH = 4
) (
   input  logic          ck,
   input  logic          rst,
   input  logic          wr,
   input  logic [VW-1:0] din,
   input  logic          rd,
   output logic [VW-1:0] dout,
   output logic          full,
   output logic          empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [VW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   cnt;

   assign full  = (cnt == (AW+1)'(DEPTH));
   assign empty = (cnt == '0);
   assign dout  = empty ? '0 : mem[rptr];

   // Storage is deliberately left out of reset; only the bookkeeping clears.
   always_ff @(posedge ck) begin
      if (wr) mem[wptr] <= din;
   end

   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (wr) wptr <= wptr + AW'(1);
         if (rd) rptr <= rptr + AW'(1);
         case ({wr, rd})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/tag_demux_ddf.sv
// Strips the tag from incoming tokens and routes each value into its own flux buffer.
module tag_demux_ddf
   import tag_demux_pkg::*;
#(
   parameter  int unsigned FLUX      = 2,
   parameter  int unsigned WIDTH     = 8,
   parameter  int unsigned DEPTH     = 4,
   localparam int unsigned TAG_WIDTH = tag_w(FLUX),
   localparam int unsigned VW        = WIDTH - TAG_WIDTH
) (
   input  logic                ck,
   input  logic                rst,
   input  logic [WIDTH-1:0]    in0_data,
   input  logic                in0_empty,
   output logic                in0_read,
   output logic [FLUX*VW-1:0]  out_data,
   output logic [FLUX-1:0]     out_wr,
   input  logic [FLUX-1:0]     out_full,
   output logic                err_tag,
   output logic [DROP_W-1:0]   drop_cnt
);

   if (!params_ok(FLUX, DEPTH)) begin : g_bad_params
      $error("tag_demux_ddf: FLUX must be >= 2 and DEPTH a power of 2 >= 2");
   end

   logic [TAG_WIDTH-1:0] tag;
   logic [VW-1:0]        val;
   logic [FLUX-1:0]      sel;
   logic [FLUX-1:0]      full_v;
   logic [FLUX-1:0]      empty_v;
   logic [FLUX-1:0]      wr_v;
   logic                 tag_ok;
   logic                 drop;

   assign tag = in0_data[WIDTH-1 -: TAG_WIDTH];
   assign val = in0_data[VW-1:0];

   // One-hot flux select; all-zero means the tag names no existing flux.
   always_comb begin
      sel = '0;
      for (int unsigned f = 0; f < FLUX; f++) begin
         if (32'(tag) == f) sel[f] = 1'b1;
      end
   end

   assign tag_ok   = |sel;
   assign in0_read = rst && !in0_empty && (!tag_ok || !(|(sel & full_v)));
   assign wr_v     = sel & {FLUX{in0_read}};
   assign out_wr   = ~empty_v & ~out_full;
   assign drop     = in0_read && !tag_ok;

   for (genvar f = 0; f < FLUX; f++) begin : g_flux
      tag_fifo #(
         .VW    (VW),
         .DEPTH (DEPTH)
      ) u_fifo (
         .ck    (ck),
         .rst   (rst),
         .wr    (wr_v[f]),
         .din   (val),
         .rd    (out_wr[f]),
         .dout  (out_data[f*VW +: VW]),
         .full  (full_v[f]),
         .empty (empty_v[f])
      );
   end

   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         err_tag  <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         err_tag <= 1'b1;
         if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
      end
   end

endmodule

// File: tb/tb_tag_demux_ddf.sv
// Scoreboard bench: per-flux expected-value queues double as the occupancy model.
module tb_tag_demux_ddf;

   localparam int unsigned DEPTH = 4;

   logic        ck = 1'b0;
   logic        rst = 1'b0;

   logic [7:0]  in0_data = '0;
   logic        in0_empty = 1'b1;
   logic        in0_read;
   logic [13:0] out_data;
   logic [1:0]  out_wr;
   logic [1:0]  out_full = '0;
   logic        err_tag;
   logic [7:0]  drop_cnt;

   logic [7:0]  in0_data3 = '0;
   logic        in0_empty3 = 1'b1;
   logic        in0_read3;
   logic [17:0] out_data3;
   logic [2:0]  out_wr3;
   logic [2:0]  out_full3 = '0;
   logic        err_tag3;
   logic [7:0]  drop_cnt3;

   int unsigned tests = 0;
   int unsigned fails = 0;
   int unsigned full_mode = 0;
   int unsigned waited;
   logic [6:0]  q [2][$];
   logic        mon_rd;
   logic        mon_wr;

   always #5 ck = ~ck;

   tag_demux_ddf #(.FLUX(2), .WIDTH(8), .DEPTH(DEPTH)) dut (
      .ck(ck), .rst(rst), .in0_data(in0_data), .in0_empty(in0_empty), .in0_read(in0_read),
      .out_data(out_data), .out_wr(out_wr), .out_full(out_full), .err_tag(err_tag), .drop_cnt(drop_cnt)
   );

   tag_demux_ddf #(.FLUX(3), .WIDTH(8), .DEPTH(DEPTH)) dut3 (
      .ck(ck), .rst(rst), .in0_data(in0_data3), .in0_empty(in0_empty3), .in0_read(in0_read3),
      .out_data(out_data3), .out_wr(out_wr3), .out_full(out_full3), .err_tag(err_tag3), .drop_cnt(drop_cnt3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Present one token and hold it until the DUT pops it; expected value enters the scoreboard.
   task automatic send(input int unsigned tag, input int unsigned val, input int unsigned budget,
                       output int unsigned nwait);
      in0_data  = {1'(tag), 7'(val)};
      in0_empty = 1'b0;
      nwait     = 0;
      forever begin
         @(negedge ck);
         if (in0_read) begin
            @(posedge ck);
            q[tag].push_back(7'(val));
            #1 in0_empty = 1'b1;
            return;
         end
         nwait++;
         if (nwait > budget) begin
            chk("send_timeout", 32'(nwait), 32'(budget));
            @(posedge ck);
            #1 in0_empty = 1'b1;
            return;
         end
         @(posedge ck);
         #1;
      end
   endtask

   task automatic drain(input int unsigned budget);
      int unsigned n = 0;
      while (q[0].size() != 0 || q[1].size() != 0) begin
         @(posedge ck);
         #1 n++;
         if (n > budget) begin
            chk("drain_timeout", 32'(q[0].size() + q[1].size()), 0);
            return;
         end
      end
   endtask

   // Monitor: compares strobes and head values against the queue model, then retires emitted values.
   initial forever begin
      @(negedge ck);
      if (!rst) begin
         chk("rst_in0_read", 32'(in0_read), 0);
         chk("rst_out_wr", 32'(out_wr), 0);
         chk("rst_out_data", 32'(out_data), 0);
      end else begin
         mon_rd = !in0_empty && (q[in0_data[7]].size() != DEPTH);
         chk("in0_read", 32'(in0_read), 32'(mon_rd));
         for (int f = 0; f < 2; f++) begin
            mon_wr = (q[f].size() != 0) && !out_full[f];
            chk($sformatf("out_wr[%0d]", f), 32'(out_wr[f]), 32'(mon_wr));
            if (mon_wr) begin
               chk($sformatf("out_data[%0d]", f), 32'(out_data[f*7 +: 7]), 32'(q[f][0]));
               void'(q[f].pop_front());
            end
         end
      end
   end

   initial forever begin
      @(posedge ck);
      #1;
      case (full_mode)
         1: out_full = 2'($urandom);
         2: out_full[0] = ~out_full[0];
         default: ;
      endcase
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge ck);
      #1 rst = 1'b1;
      #1;
      chk("init_err_tag", 32'(err_tag), 0);
      chk("init_drop_cnt", 32'(drop_cnt), 0);
      chk("init_out_wr", 32'(out_wr), 0);
      @(posedge ck);
      #1;

      // Basic routing, back to back
      send(0, 5, 10, waited);
      send(1, 3, 10, waited);
      drain(10);

      // Reset mid-stream with three flux-1 tokens buffered
      out_full = 2'b10;
      for (int v = 1; v <= 3; v++) send(1, v, 10, waited);
      in0_data  = 8'h05;
      in0_empty = 1'b0;
      rst       = 1'b0;
      q[0].delete();
      q[1].delete();
      repeat (3) @(posedge ck);
      #1;
      in0_empty = 1'b1;
      out_full  = 2'b00;
      rst       = 1'b1;
      repeat (6) @(posedge ck);
      #1;

      // Head-of-line isolation
      out_full = 2'b10;
      for (int v = 10; v < 14; v++) send(1, v, 10, waited);
      for (int v = 20; v < 23; v++) send(0, v, 10, waited);
      in0_data  = {1'b1, 7'd14};
      in0_empty = 1'b0;
      repeat (5) @(posedge ck);
      @(negedge ck);
      chk("hol_blocked", 32'(in0_read), 0);
      @(posedge ck);
      #1 out_full = 2'b00;
      send(1, 14, 10, waited);
      drain(20);

      // Full boundary: refused at cnt=4, accepted next cycle at cnt=3 with a concurrent pop
      out_full = 2'b01;
      for (int v = 30; v < 34; v++) send(0, v, 10, waited);
      out_full = 2'b00;
      send(0, 34, 10, waited);
      chk("full_refuse_cycles", 32'(waited), 1);
      drain(20);

      // Wrap-around with out_full[0] toggling every cycle
      full_mode = 2;
      for (int v = 0; v < 10; v++) send(0, v, 20, waited);
      full_mode = 0;
      out_full  = 2'b00;
      drain(30);

      // Randomized traffic with random backpressure
      full_mode = 1;
      for (int i = 0; i < 150; i++) begin
         send($urandom_range(1), $urandom_range(127), 100, waited);
         if ($urandom_range(3) == 0) begin
            @(posedge ck);
            #1;
         end
      end
      full_mode = 0;
      out_full  = 2'b00;
      drain(30);
      chk("flux2_err_tag", 32'(err_tag), 0);
      chk("flux2_drop_cnt", 32'(drop_cnt), 0);

      // Invalid tag on the three-flux instance
      @(posedge ck);
      #1;
      in0_data3  = 8'hC5;
      in0_empty3 = 1'b0;
      #1 chk("inv_read", 32'(in0_read3), 1);
      @(negedge ck);
      chk("inv_no_wr", 32'(out_wr3), 0);
      @(posedge ck);
      #1 in0_empty3 = 1'b1;
      chk("inv_err_tag", 32'(err_tag3), 1);
      chk("inv_drop_1", 32'(drop_cnt3), 1);
      @(negedge ck);
      chk("inv_no_wr_after", 32'(out_wr3), 0);

      @(posedge ck);
      #1;
      in0_data3  = 8'h45;
      in0_empty3 = 1'b0;
      #1 chk("f3_valid_read", 32'(in0_read3), 1);
      @(posedge ck);
      #1 in0_empty3 = 1'b1;
      @(negedge ck);
      chk("f3_valid_wr", 32'(out_wr3), 32'h2);
      chk("f3_valid_data", 32'(out_data3[11:6]), 5);

      @(posedge ck);
      #1 in0_empty3 = 1'b0;
      for (int i = 0; i < 300; i++) begin
         in0_data3 = {2'd3, 6'($urandom)};
         @(posedge ck);
         #1;
      end
      in0_empty3 = 1'b1;
      chk("inv_drop_sat", 32'(drop_cnt3), 255);
      chk("inv_err_sticky", 32'(err_tag3), 1);
      chk("inv_no_wr_end", 32'(out_wr3), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
